// File: rtl/la_trace_reader_pkg.sv
// Shared logic-analyzer definitions.
// Used by both the trace reader and the capture-side control.
package la_pkg;

  localparam int LA_ADDR_W = 8;
  localparam int LA_DATA_W = 32;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FETCH   = 2'd1;
  localparam logic [1:0] S_LAT     = 2'd2;
  localparam logic [1:0] S_PRESENT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = S_IDLE,
    ST_FETCH   = S_FETCH,
    ST_LAT     = S_LAT,
    ST_PRESENT = S_PRESENT
  } la_state_t;

endpackage

// File: rtl/la_trace_reader_if.sv
// Valid/ready sample stream from the trace reader to the host port.
// master drives samples, slave accepts them.
interface la_trace_reader_if
  import la_pkg::*;
#(
  parameter int DATA_W = LA_DATA_W
);

  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready;
  logic              rd_last;

  modport master (
    output rd_data,
    output rd_valid,
    output rd_last,
    input  rd_ready
  );

  modport slave (
    input  rd_data,
    input  rd_valid,
    input  rd_last,
    output rd_ready
  );

endinterface

// File: rtl/la_trace_reader.sv
// Trace RAM read-side controller.
// Replays the captured window oldest-first to the host stream.
module la_trace_reader
  import la_pkg::*;
#(
  parameter int ADDR_W = LA_ADDR_W,
  parameter int DATA_W = LA_DATA_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              la_run,
  input  logic [ADDR_W-1:0] wr_ptr,
  input  logic              wrapped,
  input  logic              rd_start,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy,
  output logic              done,
  output logic              abort,
  la_trace_reader_if.master rd
);

  localparam logic [ADDR_W:0] FULL =
    {1'b1, {ADDR_W{1'b0}}};

  la_state_t         state;
  logic [ADDR_W:0]   remaining;
  logic [ADDR_W-1:0] base_init;
  logic [ADDR_W:0]   rem_init;

  // Window start and length as seen at the request.
  assign base_init = wrapped ? wr_ptr : '0;
  assign rem_init  = wrapped ? FULL : {1'b0, wr_ptr};

  assign busy = (state != ST_IDLE);

  // Dump sequencer: fetch, wait for RAM, present, repeat.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= ST_IDLE;
      remaining   <= '0;
      ram_re      <= 1'b0;
      ram_addr    <= '0;
      done        <= 1'b0;
      abort       <= 1'b0;
      rd.rd_data  <= '0;
      rd.rd_valid <= 1'b0;
      rd.rd_last  <= 1'b0;
    end else begin
      done   <= 1'b0;
      abort  <= 1'b0;
      ram_re <= 1'b0;
      if (busy && la_run) begin
        // Capture restarted: the window is no
        // longer coherent, so drop the dump.
        state       <= ST_IDLE;
        rd.rd_valid <= 1'b0;
        rd.rd_last  <= 1'b0;
        abort       <= 1'b1;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (rd_start && !la_run) begin
              remaining <= rem_init;
              if (rem_init == '0) begin
                done <= 1'b1;
              end else begin
                state    <= ST_FETCH;
                ram_re   <= 1'b1;
                ram_addr <= base_init;
              end
            end
          end
          ST_FETCH: begin
            state <= ST_LAT;
          end
          ST_LAT: begin
            rd.rd_data  <= ram_dout;
            rd.rd_valid <= 1'b1;
            rd.rd_last  <= (remaining == 1);
            state       <= ST_PRESENT;
          end
          ST_PRESENT: begin
            if (rd.rd_ready) begin
              rd.rd_valid <= 1'b0;
              rd.rd_last  <= 1'b0;
              remaining   <= remaining - 1'b1;
              ram_addr    <= ram_addr + 1'b1;
              if (remaining == 1) begin
                done  <= 1'b1;
                state <= ST_IDLE;
              end else begin
                ram_re <= 1'b1;
                state  <= ST_FETCH;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_la_trace_reader.sv
// Directed bench for la_trace_reader (8-entry trace RAM).
// Dump table plus hand sequences for empty/blocked/abort/reset.
module tb_la_trace_reader;

  localparam int AW = 3;
  localparam int DW = 32;

  logic          CLK;
  logic          RESET;
  logic          la_run;
  logic [AW-1:0] wr_ptr;
  logic          wrapped;
  logic          rd_start;
  logic          ram_re;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dout;
  logic          busy;
  logic          done;
  logic          abort;

  la_trace_reader_if #(.DATA_W(DW)) rd_if ();

  la_trace_reader #(
    .ADDR_W(AW),
    .DATA_W(DW)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .la_run  (la_run),
    .wr_ptr  (wr_ptr),
    .wrapped (wrapped),
    .rd_start(rd_start),
    .ram_re  (ram_re),
    .ram_addr(ram_addr),
    .ram_dout(ram_dout),
    .busy    (busy),
    .done    (done),
    .abort   (abort),
    .rd      (rd_if.master)
  );

  logic [DW-1:0] mem [8];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (ram_re) ram_dout <= mem[ram_addr];
  end

  int total = 0;
  int bad   = 0;

  typedef struct {
    string         nm;
    logic [AW-1:0] wp;
    logic          wr;
    int            n;
    logic [AW-1:0] a0;
    int            stall;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic dump(input vec_t v);
    int got = 0;
    int fetch = 0;
    int first = -1;
    int stalls = 0;
    int cyc = 0;
    int last_hs = -10;
    int done_cyc = -1;
    logic [AW-1:0] ea;
    wr_ptr   = v.wp;
    wrapped  = v.wr;
    rd_start = 1'b1;
    rd_if.rd_ready = 1'b1;
    while (cyc < 100 && done_cyc < 0) begin
      tick();
      rd_start = 1'b0;
      wr_ptr   = ~v.wp;
      wrapped  = ~v.wr;
      cyc++;
      if (ram_re) begin
        ea = v.a0 + AW'(fetch);
        chk({v.nm, ".addr"}, 32'(ram_addr), 32'(ea));
        fetch++;
      end
      if (rd_if.rd_valid) begin
        if (first < 0) first = cyc;
        chk({v.nm, ".done_vs_valid"}, 32'(done), 0);
        ea = v.a0 + AW'(got);
        chk({v.nm, ".data"}, rd_if.rd_data, mem[ea]);
        if (got == v.stall && stalls < 4) begin
          rd_if.rd_ready = 1'b0;
          stalls++;
        end else begin
          rd_if.rd_ready = 1'b1;
          chk({v.nm, ".last"}, 32'(rd_if.rd_last),
              32'(got == v.n - 1));
          got++;
          last_hs = cyc;
        end
      end
      if (done) done_cyc = cyc;
    end
    chk({v.nm, ".count"}, got, v.n);
    chk({v.nm, ".fetches"}, fetch, v.n);
    chk({v.nm, ".latency"}, first, 3);
    chk({v.nm, ".done_at"}, done_cyc, last_hs + 1);
    tick();
    chk({v.nm, ".idle"}, {busy, done, rd_if.rd_valid}, 0);
  endtask

  initial begin
    vecs[0] = '{"partial5", 3'd5, 1'b0, 5, 3'd0, -1};
    vecs[1] = '{"wrap6",    3'd6, 1'b1, 8, 3'd6, -1};
    vecs[2] = '{"stall2",   3'd2, 1'b0, 2, 3'd0, 1};
    vecs[3] = '{"wrap0",    3'd0, 1'b1, 8, 3'd0, 5};
    vecs[4] = '{"partial7", 3'd7, 1'b0, 7, 3'd0, 3};

    for (int i = 0; i < 8; i++)
      mem[i] = 32'hC0DE_0000 + 32'(i * 17 + 1);

    RESET = 1'b1;
    la_run = 1'b0;
    wr_ptr = '0;
    wrapped = 1'b0;
    rd_start = 1'b0;
    rd_if.rd_ready = 1'b0;
    tick();
    tick();
    chk("rst.outs",
        {ram_re, busy, done, abort,
         rd_if.rd_valid, rd_if.rd_last}, 0);
    chk("rst.addr", 32'(ram_addr), 0);
    chk("rst.data", rd_if.rd_data, 0);
    RESET = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) dump(vecs[i]);

    // Empty buffer: done pulse only.
    wr_ptr = 3'd0;
    wrapped = 1'b0;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    chk("empty.done", 32'(done), 1);
    chk("empty.quiet", {busy, ram_re, rd_if.rd_valid}, 0);
    tick();
    chk("empty.after", {done, busy, ram_re, rd_if.rd_valid}, 0);

    // Request during capture is ignored.
    la_run = 1'b1;
    wr_ptr = 3'd5;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("blocked", {ram_re, busy, done, abort}, 0);
    end
    la_run = 1'b0;
    tick();

    // Abort after the second sample.
    begin
      int hs = 0;
      int c = 0;
      wr_ptr = 3'd5;
      wrapped = 1'b0;
      rd_start = 1'b1;
      rd_if.rd_ready = 1'b1;
      while (hs < 2 && c < 40) begin
        tick();
        rd_start = 1'b0;
        c++;
        if (rd_if.rd_valid) hs++;
      end
      chk("abort.reach", hs, 2);
      tick();
      la_run = 1'b1;
      tick();
      chk("abort.pulse", 32'(abort), 1);
      chk("abort.quiet",
          {rd_if.rd_valid, rd_if.rd_last, busy, done}, 0);
      for (int i = 0; i < 3; i++) begin
        tick();
        chk("abort.after", {abort, done, busy}, 0);
      end
      la_run = 1'b0;
      tick();
    end

    // Reset while presenting, then restart.
    wr_ptr = 3'd5;
    wrapped = 1'b0;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    tick();
    tick();
    chk("mid.present", 32'(rd_if.rd_valid), 1);
    RESET = 1'b1;
    #1;
    chk("mid.outs",
        {ram_re, busy, done, abort,
         rd_if.rd_valid, rd_if.rd_last}, 0);
    chk("mid.data", rd_if.rd_data, 0);
    #2;
    RESET = 1'b0;
    dump(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
